// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory and
// presents fetched words (or NOP bubbles) to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_freeze,
    output logic        fetch_flush
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_buf_q, instr_buf_d;
    logic [31:0] redir_addr_q, redir_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            instr_buf_q  <= '0;
            redir_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_buf_q  <= instr_buf_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_buf_d  = instr_buf_q;
        redir_addr_d = redir_addr_q;
        case (state_q)
            S_REQ: begin
                if (branch_taken) begin
                    // A redirect mid-request parks the target until the
                    // outstanding response has been consumed.
                    if (mem_ack) begin
                        pc_d = branch_addr;
                    end else begin
                        redir_addr_d = branch_addr;
                        state_d      = S_DROP;
                    end
                end else if (mem_ack) begin
                    instr_buf_d = mem_rdata;
                    state_d     = S_VALID;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = S_REQ;
                end else if (!hazard_stall) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (mem_ack) begin
                    pc_d    = branch_taken ? branch_addr : redir_addr_q;
                    state_d = S_REQ;
                end else if (branch_taken) begin
                    redir_addr_d = branch_addr;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        mem_req         = 1'b0;
        mem_addr        = '0;
        pc_out          = '0;
        instruction_out = '0;
        fetch_freeze    = 1'b0;
        fetch_flush     = 1'b0;
        if (!rst) begin
            mem_addr        = pc_q;
            instruction_out = NOP_WORD;
            fetch_freeze    = hazard_stall;
            fetch_flush     = branch_taken;
            case (state_q)
                S_REQ, S_DROP: mem_req = 1'b1;
                S_VALID: begin
                    instruction_out = instr_buf_q;
                    pc_out          = pc_q + PC_STEP;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

endmodule
